// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing control for PC, IF/ID, ID/EX: load-use bubbles, redirect flush, mem-busy freeze.
// Latency: outputs combinational from state+inputs; mem_busy_i freezes every stage (watchdog flags long waits).
// Optional HAZ_PERF_CNT_EN adds saturating stall_cycles_o / flush_events_o counters.
module pipeline_hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_branch_taken_i,
    input  logic       ex_jalr_i,
    input  logic       mem_busy_i,
    output logic       pc_write_en_o,
    output logic       if_id_write_en_o,
    output logic       id_ex_write_en_o,
    output logic       if_id_flush_o,
    output logic       id_ex_flush_o,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_events_o,
`endif
    output logic       mem_timeout_o
);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    localparam logic [2:0] BUBBLE_INIT = 3'(LOAD_LAT - 1);
    localparam logic [7:0] WAIT_MAX    = 8'(MAX_WAIT);

    state_t     state_q, state_d, resume_q, resume_d, eff_state;
    logic [2:0] bubble_q, bubble_d;
    logic [7:0] wait_q, wait_d;
    logic       timeout_d;
    logic       load_use, redirect;

    assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                      ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
    assign redirect = ex_branch_taken_i | ex_jalr_i;

    // The cycle memory becomes ready already behaves as the interrupted state.
    assign eff_state = (state_q == MEM_WAIT) ? resume_q : state_q;

    always_comb begin
        pc_write_en_o    = 1'b0;
        if_id_write_en_o = 1'b0;
        id_ex_write_en_o = 1'b0;
        if_id_flush_o    = 1'b0;
        id_ex_flush_o    = 1'b0;
        state_d          = state_q;
        resume_d         = resume_q;
        bubble_d         = bubble_q;
        wait_d           = wait_q;
        timeout_d        = mem_timeout_o;

        if (mem_busy_i && (state_q == MEM_WAIT)) begin
            if (wait_q == WAIT_MAX) begin
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end else if (mem_busy_i) begin
            state_d  = MEM_WAIT;
            resume_d = state_q;
            wait_d   = 8'd1;
        end else begin
            wait_d  = 8'd0;
            state_d = eff_state;
            if (redirect) begin
                // Squashing ID makes any coincident load-use irrelevant.
                pc_write_en_o    = 1'b1;
                if_id_write_en_o = 1'b1;
                id_ex_write_en_o = 1'b1;
                if_id_flush_o    = 1'b1;
                id_ex_flush_o    = 1'b1;
                state_d          = RUN;
                bubble_d         = 3'd0;
            end else if ((eff_state == LU_STALL) || load_use) begin
                id_ex_write_en_o = 1'b1;
                id_ex_flush_o    = 1'b1;
                if (eff_state == LU_STALL) begin
                    if (bubble_q > 3'd1) begin
                        bubble_d = bubble_q - 3'd1;
                        state_d  = LU_STALL;
                    end else begin
                        bubble_d = 3'd0;
                        state_d  = RUN;
                    end
                end else if (LOAD_LAT > 1) begin
                    bubble_d = BUBBLE_INIT;
                    state_d  = LU_STALL;
                end else begin
                    state_d  = RUN;
                end
            end else begin
                pc_write_en_o    = 1'b1;
                if_id_write_en_o = 1'b1;
                id_ex_write_en_o = 1'b1;
            end
        end

        if (reset) begin
            pc_write_en_o    = 1'b0;
            if_id_write_en_o = 1'b0;
            id_ex_write_en_o = 1'b0;
            if_id_flush_o    = 1'b0;
            id_ex_flush_o    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            resume_q      <= RUN;
            bubble_q      <= 3'd0;
            wait_q        <= 8'd0;
            mem_timeout_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            resume_q      <= resume_d;
            bubble_q      <= bubble_d;
            wait_q        <= wait_d;
            mem_timeout_o <= timeout_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_o <= 32'd0;
            flush_events_o <= 32'd0;
        end else begin
            if (!pc_write_en_o && (stall_cycles_o != 32'hFFFF_FFFF))
                stall_cycles_o <= stall_cycles_o + 32'd1;
            if (if_id_flush_o && (flush_events_o != 32'hFFFF_FFFF))
                flush_events_o <= flush_events_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LOAD_LAT=1/MAX_WAIT=255 and LOAD_LAT=3/MAX_WAIT=4).
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] rs1, rs2, rd;
    logic       u1s, u2s, mr, bt, jalr, busy;
    logic       pc1, ifw1, idw1, iff1, idf1, to1;
    logic       pc3, ifw3, idw3, iff3, idf3, to3;
    logic [4:0] o1, o3;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] st1, fl1, st3, fl3;
`endif

    assign o1 = {pc1, ifw1, idw1, iff1, idf1};
    assign o3 = {pc3, ifw3, idw3, iff3, idf3};

    localparam logic [4:0] NORM = 5'b11100;
    localparam logic [4:0] BUB  = 5'b00101;
    localparam logic [4:0] REDIR = 5'b11111;
    localparam logic [4:0] FRZ  = 5'b00000;

    pipeline_hazard_ctrl #(.LOAD_LAT(1), .MAX_WAIT(255)) u1 (
        .clk(clk), .reset(reset), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_uses_rs1_i(u1s), .id_uses_rs2_i(u2s), .ex_rd_i(rd),
        .ex_mem_read_i(mr), .ex_branch_taken_i(bt), .ex_jalr_i(jalr),
        .mem_busy_i(busy), .pc_write_en_o(pc1), .if_id_write_en_o(ifw1),
        .id_ex_write_en_o(idw1), .if_id_flush_o(iff1), .id_ex_flush_o(idf1),
`ifdef HAZ_PERF_CNT_EN
        .stall_cycles_o(st1), .flush_events_o(fl1),
`endif
        .mem_timeout_o(to1));

    pipeline_hazard_ctrl #(.LOAD_LAT(3), .MAX_WAIT(4)) u3 (
        .clk(clk), .reset(reset), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_uses_rs1_i(u1s), .id_uses_rs2_i(u2s), .ex_rd_i(rd),
        .ex_mem_read_i(mr), .ex_branch_taken_i(bt), .ex_jalr_i(jalr),
        .mem_busy_i(busy), .pc_write_en_o(pc3), .if_id_write_en_o(ifw3),
        .id_ex_write_en_o(idw3), .if_id_flush_o(iff3), .id_ex_flush_o(idf3),
`ifdef HAZ_PERF_CNT_EN
        .stall_cycles_o(st3), .flush_events_o(fl3),
`endif
        .mem_timeout_o(to3));

    int errors = 0;
    int checks = 0;

    // Reference model: bubbles still owed, consecutive busy cycles seen, sticky timeout.
    int   pend[2];
    int   bcnt[2];
    logic to_m[2];
    int   lat[2] = '{1, 3};
    int   mw[2]  = '{255, 4};

    function automatic logic hazard();
        return mr && (rd != 5'd0) && ((u1s && rs1 == rd) || (u2s && rs2 == rd));
    endfunction

    function automatic logic [4:0] m_out(int k);
        if (reset) return FRZ;
        if (busy) return FRZ;
        if (bt || jalr) return REDIR;
        if (pend[k] > 0 || hazard()) return BUB;
        return NORM;
    endfunction

    task automatic m_update();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                pend[k] = 0; bcnt[k] = 0; to_m[k] = 1'b0;
            end else if (busy) begin
                if (bcnt[k] == mw[k]) to_m[k] = 1'b1;
                bcnt[k] = (bcnt[k] + 1 > mw[k]) ? mw[k] : bcnt[k] + 1;
            end else begin
                bcnt[k] = 0;
                if (bt || jalr) pend[k] = 0;
                else if (pend[k] > 0) pend[k] = pend[k] - 1;
                else if (hazard()) pend[k] = lat[k] - 1;
            end
        end
    endtask

    task automatic tick();
        m_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; u1s = 1'b0; u2s = 1'b0;
        mr = 1'b0; bt = 1'b0; jalr = 1'b0; busy = 1'b0;
    endtask

    task automatic set_hazard();
        idle();
        mr = 1'b1; rd = 5'd5; rs1 = 5'd5; u1s = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1; idle(); tick(); reset = 1'b0; #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; set_hazard(); jalr = 1'b1; #1;
        checks++;
        if ({o1, o3} !== 10'd0) begin errors++; $display("FAIL reset_outputs: got %b want %b", {o1, o3}, 10'd0); end
        tick();
        checks++;
        if ({to1, to3} !== 2'b00) begin errors++; $display("FAIL reset_timeout: got %b want 00", {to1, to3}); end
        reset = 1'b0; idle(); #1;
        checks++;
        if ({o1, o3} !== {NORM, NORM}) begin errors++; $display("FAIL reset_release: got %b want %b", {o1, o3}, {NORM, NORM}); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_hazard(); #1;
        checks++;
        if ({o1, o3} !== {BUB, BUB}) begin errors++; $display("FAIL lu_first: got %b want %b", {o1, o3}, {BUB, BUB}); end
        tick(); idle(); #1;
        checks++;
        if ({o1, o3} !== {NORM, BUB}) begin errors++; $display("FAIL lu_second: got %b want %b", {o1, o3}, {NORM, BUB}); end
        tick(); #1;
        checks++;
        if (o3 !== BUB) begin errors++; $display("FAIL lu_third_lat3: got %b want %b", o3, BUB); end
        tick(); #1;
        checks++;
        if ({o1, o3} !== {NORM, NORM}) begin errors++; $display("FAIL lu_done: got %b want %b", {o1, o3}, {NORM, NORM}); end
    endtask

    task automatic test_x0_unused();
        do_reset();
        idle(); mr = 1'b1; rd = 5'd0; rs1 = 5'd0; u1s = 1'b1; #1;
        checks++;
        if ({o1, o3} !== {NORM, NORM}) begin errors++; $display("FAIL x0_no_stall: got %b want %b", {o1, o3}, {NORM, NORM}); end
        idle(); mr = 1'b1; rd = 5'd6; rs2 = 5'd6; u2s = 1'b0; rs1 = 5'd1; u1s = 1'b1; #1;
        checks++;
        if ({o1, o3} !== {NORM, NORM}) begin errors++; $display("FAIL rs2_unused: got %b want %b", {o1, o3}, {NORM, NORM}); end
        u2s = 1'b1; #1;
        checks++;
        if ({o1, o3} !== {BUB, BUB}) begin errors++; $display("FAIL rs2_used: got %b want %b", {o1, o3}, {BUB, BUB}); end
        idle(); #1;
    endtask

    task automatic test_lat3_busy();
        do_reset();
        set_hazard(); #1;
        checks++;
        if ({o1, o3} !== {BUB, BUB}) begin errors++; $display("FAIL lb_first: got %b want %b", {o1, o3}, {BUB, BUB}); end
        tick(); idle(); #1;
        checks++;
        if ({o1, o3} !== {NORM, BUB}) begin errors++; $display("FAIL lb_second: got %b want %b", {o1, o3}, {NORM, BUB}); end
        tick();
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({o1, o3} !== {FRZ, FRZ}) begin errors++; $display("FAIL lb_freeze%0d: got %b want %b", i, {o1, o3}, {FRZ, FRZ}); end
            tick();
        end
        busy = 1'b0; #1;
        checks++;
        if ({o1, o3} !== {NORM, BUB}) begin errors++; $display("FAIL lb_resume_bubble: got %b want %b", {o1, o3}, {NORM, BUB}); end
        tick(); #1;
        checks++;
        if ({o1, o3, to3} !== {NORM, NORM, 1'b0}) begin errors++; $display("FAIL lb_done: got %b want %b", {o1, o3, to3}, {NORM, NORM, 1'b0}); end
    endtask

    task automatic test_redirect();
        do_reset();
        set_hazard(); jalr = 1'b1; #1;
        checks++;
        if ({o1, o3} !== {REDIR, REDIR}) begin errors++; $display("FAIL jalr_lu: got %b want %b", {o1, o3}, {REDIR, REDIR}); end
        tick(); idle(); #1;
        checks++;
        if ({o1, o3} !== {NORM, NORM}) begin errors++; $display("FAIL jalr_after: got %b want %b", {o1, o3}, {NORM, NORM}); end
        set_hazard(); bt = 1'b1; #1;
        checks++;
        if ({o1, o3} !== {REDIR, REDIR}) begin errors++; $display("FAIL br_lu: got %b want %b", {o1, o3}, {REDIR, REDIR}); end
        tick(); idle(); #1;
        checks++;
        if ({o1, o3} !== {NORM, NORM}) begin errors++; $display("FAIL br_after: got %b want %b", {o1, o3}, {NORM, NORM}); end
    endtask

    task automatic test_watchdog();
        do_reset();
        busy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if ({to1, to3} !== {1'b0, (i >= 5)}) begin errors++; $display("FAIL wd_edge%0d: got %b want %b", i, {to1, to3}, {1'b0, (i >= 5)}); end
        end
        busy = 1'b0; tick(); #1;
        checks++;
        if ({o3, to3} !== {NORM, 1'b1}) begin errors++; $display("FAIL wd_sticky: got %b want %b", {o3, to3}, {NORM, 1'b1}); end
        do_reset();
        checks++;
        if (to3 !== 1'b0) begin errors++; $display("FAIL wd_clear: got %b want 0", to3); end
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        set_hazard(); tick();
        idle(); tick();
        set_hazard(); tick();
        idle(); jalr = 1'b1; tick();
        idle(); #1;
        checks++;
        if ({st1, fl1} !== {32'd2, 32'd1}) begin errors++; $display("FAIL perf: stall=%0d flush=%0d want 2 1", st1, fl1); end
    endtask
`endif

    task automatic test_random();
        int burst;
        burst = 0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            u1s = 1'($urandom_range(0, 1)); u2s = 1'($urandom_range(0, 1));
            mr  = 1'($urandom_range(0, 1));
            bt  = ($urandom_range(0, 9) == 0);
            jalr = ($urandom_range(0, 15) == 0);
            if (burst == 0 && $urandom_range(0, 11) == 0) burst = $urandom_range(1, 8);
            busy = (burst > 0) || ($urandom_range(0, 7) == 0);
            if (burst > 0) burst--;
            #1;
            checks++;
            if ({o1, to1, o3, to3} !== {m_out(0), to_m[0], m_out(1), to_m[1]})
            begin
                errors++;
                $display("FAIL random cycle %0d: got %b want %b", n, {o1, to1, o3, to3},
                         {m_out(0), to_m[0], m_out(1), to_m[1]});
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_x0_unused();
        test_lat3_busy();
        test_redirect();
        test_watchdog();
`ifdef HAZ_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX) and the PC.
- Detects load-use hazards and inserts LOAD_LAT bubbles.
- Flushes the front end on taken branch / JALR redirects from EX.
- Freezes the whole pipeline while data memory reports busy, with a wait watchdog.
- Drives write-enable and flush inputs of the PC, IF/ID and ID/EX registers.

Parameters:
LOAD_LAT, 1, bubbles inserted per load-use hazard (1..7)
MAX_WAIT, 255, consecutive mem_busy cycles before mem_timeout_o sets (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous reset, active-high
id_rs1_i  in  5  rs1 of instruction in ID
id_rs2_i  in  5  rs2 of instruction in ID
id_uses_rs1_i  in  1  ID instruction reads rs1
id_uses_rs2_i  in  1  ID instruction reads rs2
ex_rd_i  in  5  destination register of instruction in EX
ex_mem_read_i  in  1  EX instruction is a load
ex_branch_taken_i  in  1  EX branch resolved taken
ex_jalr_i  in  1  EX instruction is JALR
mem_busy_i  in  1  data memory not ready this cycle
pc_write_en_o  out  1  PC update enable
if_id_write_en_o  out  1  IF/ID load enable
id_ex_write_en_o  out  1  ID/EX load enable
if_id_flush_o  out  1  IF/ID clear to NOP
id_ex_flush_o  out  1  ID/EX clear to bubble (all control bits 0)
mem_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Outputs are combinational from the current state and inputs. State, bubble counter, wait counter and mem_timeout_o are registered.
- reset=1 at a rising edge:
  - state=RUN, bubble_cnt=0, wait_cnt=0, mem_timeout_o=0.
  - While reset is high, all write enables=0 and both flushes=0.
- load_use = ex_mem_read_i & (ex_rd_i!=0) & ((id_uses_rs1_i & id_rs1_i==ex_rd_i) | (id_uses_rs2_i & id_rs2_i==ex_rd_i)). x0 never causes a hazard.
- redirect = ex_branch_taken_i | ex_jalr_i.
- Per-cycle priority: mem_busy_i > redirect > load_use/LU_STALL > normal.
- States:
  - RUN, normal:
    - Outputs: all write enables=1, flushes=0.
  - RUN with mem_busy_i=1:
    - Outputs: all write enables=0, flushes=0.
    - Next: MEM_WAIT; resume state=RUN saved; wait_cnt=1.
  - RUN with redirect:
    - Outputs: pc_write_en_o=1, if_id_flush_o=1, id_ex_flush_o=1.
    - A simultaneous load_use is ignored, because the ID instruction is squashed.
  - RUN with load_use:
    - Outputs: pc_write_en_o=0, if_id_write_en_o=0, id_ex_flush_o=1.
    - Next: LU_STALL with bubble_cnt=LOAD_LAT-1 if LOAD_LAT>1; otherwise stay in RUN.
  - LU_STALL:
    - Outputs: same as the load_use case.
    - bubble_cnt decrements each cycle; when it reaches 1, next state=RUN.
    - Redirect cannot occur here (EX holds a bubble). If asserted anyway, it is handled as in RUN and state returns to RUN.
  - MEM_WAIT:
    - Outputs: all write enables=0, flushes=0; bubble_cnt is held.
    - wait_cnt increments, saturating at MAX_WAIT.
    - When wait_cnt==MAX_WAIT, mem_timeout_o sets and stays set until reset.
    - On mem_busy_i=0: return to the saved state, wait_cnt=0. Outputs in that cycle are those of the saved state.
- mem_busy_i in LU_STALL: enter MEM_WAIT with saved state=LU_STALL; bubble_cnt is preserved.
- Reset asserted mid-stall or mid-wait: immediate return to RUN; the pending bubble count is discarded.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined:
  - Adds output stall_cycles_o[31:0]: counts cycles with pc_write_en_o=0.
  - Adds output flush_events_o[31:0]: counts cycles with if_id_flush_o=1.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read_i=1, ex_rd_i=5, id_rs1_i=5, id_uses_rs1_i=1, LOAD_LAT=1 -> one cycle with pc_we=0, if_id_we=0, id_ex_flush=1; next cycle all enables=1.
- x0 and unused operands: ex_rd_i=0 with matching rs1, or id_uses_rs2_i=0 with rs2==ex_rd_i -> no stall.
- LOAD_LAT=3 with hazard -> exactly 3 consecutive bubble cycles, then RUN. mem_busy_i=1 for 4 cycles in the second bubble -> freeze for 4 cycles, then exactly 1 remaining bubble.
- Redirect and load_use in the same cycle (ex_jalr_i=1) -> if_id_flush=1, id_ex_flush=1, pc_we=1, no stall in the following cycle.
- Watchdog: MAX_WAIT=4, mem_busy_i=1 for 6 cycles -> mem_timeout_o=1 from the 5th cycle edge; stays 1 after busy drops; cleared by reset=1.
- HAZ_PERF_CNT_EN defined: 2 load-use stalls + 1 redirect -> stall_cycles_o=2, flush_events_o=1.
